store_buffer: RTL and testbench

- Write-side counterpart to the load-result path; sits between the execute stage and data memory.
- Accepts store requests (address from ALUResult, data from rs2, width from funct3) and formats them into word-aligned byte-strobed writes.
- Queues the writes in a small FIFO and drains them to data memory over a valid/ready handshake.
- Forwards buffered bytes to loads so that ReadData can be merged before result selection.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/store_lane_format.sv | 46 ++++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared store-path definitions: funct3 store encodings, lane count and the
// buffered store entry layout.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int NLANES = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [NLANES-1:0] strb;
  } store_entry_t;
endpackage

// File: rtl/store_lane_format.sv
// Turns a raw store request into a word-aligned, lane-replicated, byte-strobed
// write and flags addresses that do not fit the requested width.
module store_lane_format
  import riscv_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [2:0]        funct3,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  output logic [AW-1:0]     word_addr,
  output logic [31:0]       lane_data,
  output logic [NLANES-1:0] strb,
  output logic              misaligned
);
  logic [1:0] off;

  assign off       = addr[1:0];
  assign word_addr = {addr[AW-1:2], 2'b00};

  always_comb begin
    lane_data  = '0;
    strb       = '0;
    misaligned = 1'b1;
    unique case (funct3)
      F3_SB: begin
        lane_data  = {4{wdata[7:0]}};
        strb       = 4'b0001 << off;
        misaligned = 1'b0;
      end
      F3_SH: begin
        lane_data  = {2{wdata[15:0]}};
        strb       = off[1] ? 4'b1100 : 4'b0011;
        misaligned = off[0];
      end
      F3_SW: begin
        lane_data  = wdata;
        strb       = 4'b1111;
        misaligned = (off != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/store_buffer.sv
// Small FIFO of formatted stores draining to data memory over valid/ready,
// with youngest-wins byte forwarding to loads.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       MemWrite,
  input  logic [2:0]                 funct3,
  input  logic [AW-1:0]              ALUResult,
  input  logic [DW-1:0]              WriteData,
  output logic                       StoreReady,
  output logic                       MisalignErr,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  input  logic [AW-1:0]              LoadAddr,
  output logic [NLANES-1:0]          FwdMask,
  output logic [DW-1:0]              FwdData,
  output logic                       MemWrValid,
  output logic [AW-1:0]              MemWrAddr,
  output logic [DW-1:0]              MemWrData,
  output logic [NLANES-1:0]          MemWrStrb,
  input  logic                       MemWrReady
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  store_entry_t      mem_reg [DEPTH];
  logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              empty_reg;
  logic              err_reg;
  logic              full;
  logic              push, pop;

  logic [AW-1:0]     fmt_addr;
  logic [31:0]       fmt_data;
  logic [NLANES-1:0] fmt_strb;
  logic              fmt_mis;
  store_entry_t      new_entry;
  store_entry_t      head;

  store_lane_format #(.AW(AW)) u_format (
    .funct3     (funct3),
    .addr       (ALUResult),
    .wdata      (WriteData[31:0]),
    .word_addr  (fmt_addr),
    .lane_data  (fmt_data),
    .strb       (fmt_strb),
    .misaligned (fmt_mis)
  );

  assign new_entry.addr = XLEN'(fmt_addr);
  assign new_entry.data = fmt_data;
  assign new_entry.strb = fmt_strb;

  assign full       = (count_reg == CW'(DEPTH));
  assign StoreReady = !full;
  // A full buffer refuses pushes even if the head drains on the same edge.
  assign push       = MemWrite && !full && !fmt_mis;
  assign pop        = !empty_reg && MemWrReady;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      err_reg    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= new_entry;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      err_reg   <= MemWrite && fmt_mis;
    end
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign MemWrValid  = !empty_reg;
  assign MemWrAddr   = AW'(head.addr);
  assign MemWrData   = DW'(head.data);
  assign MemWrStrb   = head.strb;
  assign Count       = count_reg;
  assign Empty       = empty_reg;
  assign MisalignErr = err_reg;

  // Walk oldest to youngest so younger matching entries overwrite older lanes.
  always_comb begin
    logic [PW-1:0] idx;
    logic [AW-1:0] eaddr;
    FwdMask = '0;
    FwdData = '0;
    idx     = '0;
    eaddr   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx   = rd_ptr_reg + PW'(k);
      eaddr = AW'(mem_reg[idx].addr);
      if ((CW'(k) < count_reg) && (eaddr[AW-1:2] == LoadAddr[AW-1:2])) begin
        for (int l = 0; l < NLANES; l++) begin
          if (mem_reg[idx].strb[l]) begin
            FwdMask[l]        = 1'b1;
            FwdData[8*l +: 8] = mem_reg[idx].data[8*l +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed plus randomized check of store_buffer against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        StoreReady;
  logic        MisalignErr;
  logic [2:0]  Count;
  logic        Empty;
  logic [31:0] LoadAddr;
  logic [3:0]  FwdMask;
  logic [31:0] FwdData;
  logic        MemWrValid;
  logic [31:0] MemWrAddr;
  logic [31:0] MemWrData;
  logic [3:0]  MemWrStrb;
  logic        MemWrReady;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q[$];
  bit   err_exp = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .StoreReady (StoreReady),
    .MisalignErr(MisalignErr),
    .Count      (Count),
    .Empty      (Empty),
    .LoadAddr   (LoadAddr),
    .FwdMask    (FwdMask),
    .FwdData    (FwdData),
    .MemWrValid (MemWrValid),
    .MemWrAddr  (MemWrAddr),
    .MemWrData  (MemWrData),
    .MemWrStrb  (MemWrStrb),
    .MemWrReady (MemWrReady)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic ent_t model_fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int   off;
    off    = int'(a[1:0]);
    e.addr = a & 32'hFFFF_FFFC;
    e.data = 32'h0;
    e.strb = 4'h0;
    if (f3 == 3'b000) begin
      e.data = d[7:0] * 32'h0101_0101;
      e.strb = 4'(1 << off);
    end else if (f3 == 3'b001) begin
      e.data = d[15:0] * 32'h0001_0001;
      e.strb = (off >= 2) ? 4'b1100 : 4'b0011;
    end else begin
      e.data = d;
      e.strb = 4'hF;
    end
    return e;
  endfunction

  task automatic check_all(input string where);
    logic [3:0]  m_mask;
    logic [31:0] m_data;
    bit          got;
    chk({where, ":ready"}, StoreReady, q.size() < DEPTH);
    chk({where, ":count"}, Count, q.size());
    chk({where, ":empty"}, Empty, q.size() == 0);
    chk({where, ":valid"}, MemWrValid, q.size() != 0);
    chk({where, ":err"}, MisalignErr, err_exp);
    if (q.size() != 0) begin
      chk({where, ":addr"}, MemWrAddr, q[0].addr);
      chk({where, ":data"}, MemWrData, q[0].data);
      chk({where, ":strb"}, MemWrStrb, q[0].strb);
    end
    m_mask = 4'h0;
    m_data = 32'h0;
    for (int l = 0; l < 4; l++) begin
      got = 1'b0;
      for (int j = q.size() - 1; j >= 0 && !got; j--) begin
        if (q[j].addr[31:2] == LoadAddr[31:2] && q[j].strb[l]) begin
          m_mask[l]        = 1'b1;
          m_data[8*l +: 8] = q[j].data[8*l +: 8];
          got              = 1'b1;
        end
      end
    end
    chk({where, ":fwdmask"}, FwdMask, m_mask);
    chk({where, ":fwddata"}, FwdData, m_data);
  endtask

  task automatic tick(input string where);
    bit   mis, push, pop;
    ent_t e;
    mis  = model_mis(funct3, ALUResult);
    push = MemWrite && (q.size() < DEPTH) && !mis;
    pop  = (q.size() != 0) && MemWrReady;
    e    = model_fmt(funct3, ALUResult, WriteData);
    @(posedge clk);
    #1;
    if (pop) q.delete(0);
    if (push) q.push_back(e);
    err_exp = MemWrite && mis;
    check_all(where);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input string where);
    MemWrite  = 1'b1;
    funct3    = f3;
    ALUResult = a;
    WriteData = d;
    tick(where);
    MemWrite  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    MemWrite   = 1'b0;
    funct3     = 3'b000;
    ALUResult  = 32'h0;
    WriteData  = 32'h0;
    LoadAddr   = 32'h0;
    MemWrReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:valid", MemWrValid, 1'b0);
    chk("rst:strb", MemWrStrb, 4'h0);
    chk("rst:addr", MemWrAddr, 32'h0);
    chk("rst:data", MemWrData, 32'h0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single SW drains the cycle after it is pushed
    MemWrReady = 1'b1;
    store(3'b010, 32'h100, 32'hDEAD_BEEF, "t1_push");
    chk("t1:addr", MemWrAddr, 32'h100);
    chk("t1:data", MemWrData, 32'hDEAD_BEEF);
    chk("t1:strb", MemWrStrb, 4'hF);
    tick("t1_pop");
    chk("t1:empty", Empty, 1'b1);

    // 2: byte and halfword formatting
    store(3'b000, 32'h203, 32'h0000_00AB, "t2_sb");
    chk("t2:sb_addr", MemWrAddr, 32'h200);
    chk("t2:sb_strb", MemWrStrb, 4'b1000);
    chk("t2:sb_data", MemWrData, 32'hABAB_ABAB);
    store(3'b001, 32'h202, 32'h0000_1234, "t2_sh");
    chk("t2:sh_strb", MemWrStrb, 4'b1100);
    chk("t2:sh_data", MemWrData, 32'h1234_1234);
    tick("t2_drain");

    // 3: fill, overflow attempt, then drain in order
    MemWrReady = 1'b0;
    for (int i = 0; i < 4; i++) store(3'b010, 32'(4 * i), 32'(32'hA0 + i), "t3_fill");
    chk("t3:count", Count, 3'd4);
    chk("t3:ready", StoreReady, 1'b0);
    store(3'b010, 32'h10, 32'hFFFF_FFFF, "t3_over");
    chk("t3:count_over", Count, 3'd4);
    MemWrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3:order", MemWrAddr, 32'(4 * i));
      tick("t3_drain");
    end
    chk("t3:empty", Empty, 1'b1);

    // 4: forwarding merge, youngest byte wins
    MemWrReady = 1'b0;
    store(3'b010, 32'h300, 32'h1122_3344, "t4_sw");
    store(3'b000, 32'h301, 32'h0000_0055, "t4_sb");
    LoadAddr = 32'h300;
    #1;
    chk("t4:mask", FwdMask, 4'hF);
    chk("t4:data", FwdData, 32'h1122_5544);
    LoadAddr = 32'h304;
    #1;
    chk("t4:miss_mask", FwdMask, 4'h0);
    chk("t4:miss_data", FwdData, 32'h0);
    MemWrReady = 1'b1;
    tick("t4_d0");
    tick("t4_d1");

    // 5: rejected requests pulse MisalignErr for exactly one cycle
    store(3'b001, 32'h101, 32'h5555, "t5_sh");
    chk("t5:err_sh", MisalignErr, 1'b1);
    tick("t5_idle0");
    chk("t5:err_clr", MisalignErr, 1'b0);
    store(3'b011, 32'h100, 32'h6666, "t5_bad");
    chk("t5:err_f3", MisalignErr, 1'b1);
    chk("t5:valid", MemWrValid, 1'b0);
    tick("t5_idle1");

    // 6: async reset mid-drain discards everything immediately
    MemWrReady = 1'b0;
    for (int i = 0; i < 3; i++) store(3'b010, 32'(32'h500 + 4 * i), 32'(i), "t6_fill");
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    err_exp = 1'b0;
    chk("t6:valid", MemWrValid, 1'b0);
    chk("t6:count", Count, 3'd0);
    chk("t6:ready", StoreReady, 1'b1);
    @(negedge clk);
    rst_n      = 1'b1;
    MemWrReady = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6_post");

    // random traffic in a small address window so forwarding hits often
    for (int n = 0; n < 400; n++) begin
      MemWrite   = ($urandom_range(0, 3) != 0);
      funct3     = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      ALUResult  = 32'h400 + 32'($urandom_range(0, 15));
      WriteData  = $urandom;
      MemWrReady = ($urandom_range(0, 2) == 0);
      LoadAddr   = 32'h400 + 32'($urandom_range(0, 15));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
